wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: RESET_VAL, default 32'h0000_0000, value loaded into x1..x31 on reset.
REQ-002 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: wb_read_data  input  32  load data from the MEM/WB register.
REQ-005 Port: wb_alu_result  input  32  ALU result from the MEM/WB register.
REQ-006 Port: wb_rd  input  5  destination register index.
REQ-007 Port: wb_mem_to_reg  input  1  1 selects load data; 0 selects ALU result.
REQ-008 Port: wb_reg_write  input  1  write enable.
REQ-009 Port: rs1_addr  input  5  ID-stage read address A.
REQ-010 Port: rs2_addr  input  5  ID-stage read address B.
REQ-011 Port: rs1_data  output  32  read data A, combinational.
REQ-012 Port: rs2_data  output  32  read data B, combinational.
REQ-013 Port: wb_value  output  32  selected writeback value, to the forwarding unit.
REQ-014 Port: wb_we_eff  output  1  effective write: wb_reg_write AND wb_rd != 0.
REQ-015 Port: wr_count  output  32  running count of committed register writes.

Function
REQ-016 wb_value SHALL equal wb_read_data when wb_mem_to_reg=1, otherwise wb_alu_result; it is combinational with no gating by wb_reg_write.
REQ-017 Storage SHALL be 31 registers, x1..x31, each 32 bits wide.
REQ-018 x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-019 On a rising clk edge with wb_we_eff=1, register[wb_rd] SHALL take wb_value; write latency is 1 cycle.
REQ-020 Reads SHALL be combinational from the current register contents, subject to the bypass rules in REQ-026 and REQ-027.
REQ-021 Both read ports SHALL be independent, and the same address on both ports SHALL return identical data.
REQ-022 wr_count SHALL increment by 1 on each rising edge with wb_we_eff=1, and SHALL wrap from 32'hFFFF_FFFF to 0 with no flag.
REQ-023 A write with wb_reg_write=1 and wb_rd=0 SHALL NOT increment wr_count.

Reset
REQ-024 While resetn=0, x1..x31 SHALL equal RESET_VAL and wr_count SHALL equal 0; the effect is immediate and does not wait for clk.
REQ-025 A reset asserted in the same cycle as a write SHALL win, and the write SHALL be lost.

Configuration
REQ-026 Macro WB_BYPASS_EN defined: when wb_we_eff=1 and rsN_addr == wb_rd, rsN_data SHALL return wb_value in the same cycle (write-through).
REQ-027 Macro WB_BYPASS_EN undefined: rsN_data SHALL return the pre-write register contents; the new value is visible in the cycle after the edge.
REQ-028 The bypass SHALL never apply to address 0, in either configuration.

Verification
REQ-029 Reset: with resetn=0 and RESET_VAL=0, read all 32 addresses -> every read is 0 and wr_count=0.
REQ-030 ALU write: wb_alu_result=32'hDEADBEEF, wb_mem_to_reg=0, wb_rd=5, wb_reg_write=1 for one edge; then rs1_addr=5 -> rs1_data=32'hDEADBEEF and wr_count=1.
REQ-031 Load write with x0 discard:
- wb_read_data=32'h1234_5678, wb_mem_to_reg=1, wb_rd=0 -> rs2_addr=0 reads 0, wr_count unchanged.
- Same data with wb_rd=31 -> x31 reads 32'h1234_5678.
REQ-032 Same-cycle read/write: x7=32'h1, write 32'h2 to x7 with rs1_addr=7 before the edge -> rs1_data=32'h2 with WB_BYPASS_EN, 32'h1 without; after the edge both configurations read 32'h2.
REQ-033 Reset mid-operation: write x3=32'hA5A5_A5A5, then pulse resetn low between clock edges -> x3 reads RESET_VAL immediately and wr_count=0.
REQ-034 Counter wrap: force wr_count to 32'hFFFF_FFFF, then perform one write to x1 -> wr_count=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback-stage register file: x0 hardwired to zero, x1..x31 storage, two combinational read ports.
// Optional feature macro WB_BYPASS_EN: same-cycle write-through from the writeback value to the read ports.
module wb_regfile #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] wb_read_data,
    input  logic [31:0] wb_alu_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_mem_to_reg,
    input  logic        wb_reg_write,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] wb_value,
    output logic        wb_we_eff,
    output logic [31:0] wr_count
);

    logic [31:0] r_regs [1:31];
    logic [31:0] r_wr_count;
    logic [31:0] w_wb_value;
    logic        w_we_eff;
    logic [31:0] w_rs1_raw;
    logic [31:0] w_rs2_raw;

    assign w_wb_value = wb_mem_to_reg ? wb_read_data : wb_alu_result;
    assign w_we_eff   = wb_reg_write && (wb_rd != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_wr_count <= 32'd0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_we_eff && (wb_rd == 5'(i))) begin
                    r_regs[i] <= w_wb_value;
                end
            end
            if (w_we_eff) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    // Address 0 falls through the mux and reads as zero.
    always_comb begin
        w_rs1_raw = 32'd0;
        w_rs2_raw = 32'd0;
        for (int i = 1; i < 32; i++) begin
            if (rs1_addr == 5'(i)) begin
                w_rs1_raw = r_regs[i];
            end
            if (rs2_addr == 5'(i)) begin
                w_rs2_raw = r_regs[i];
            end
        end
    end

`ifdef WB_BYPASS_EN
    // w_we_eff already excludes x0, so the bypass can never expose a value at address 0.
    assign rs1_data = (w_we_eff && (rs1_addr == wb_rd)) ? w_wb_value : w_rs1_raw;
    assign rs2_data = (w_we_eff && (rs2_addr == wb_rd)) ? w_wb_value : w_rs2_raw;
`else
    assign rs1_data = w_rs1_raw;
    assign rs2_data = w_rs2_raw;
`endif

    assign wb_value  = w_wb_value;
    assign wb_we_eff = w_we_eff;
    assign wr_count  = r_wr_count;

endmodule
